// File: rtl/voice_envelope.sv
// voice_envelope: per-voice ADSR envelope that gates on the note code and scales each voice sample by the level
//   clk, n_rst            clock and asynchronous active-low reset
//   sample_now            sample-rate pulse; TICK_DIV of them make one envelope step
//   note                  voice note code, 0 = no key
//   sample_in, done_in    unsigned voice sample and its valid strobe
//   sample_out, done_out  scaled sample and its strobe, one cycle after done_in
//   level                 current envelope level
//   active                high whenever the envelope is not idle
module voice_envelope #(
    parameter int TICK_DIV      = 4,
    parameter int ATTACK_STEP   = 32,
    parameter int DECAY_STEP    = 8,
    parameter int SUSTAIN_LEVEL = 128,
    parameter int RELEASE_STEP  = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       sample_now,
    input  logic [3:0] note,
    input  logic [8:0] sample_in,
    input  logic       done_in,
    output logic [8:0] sample_out,
    output logic       done_out,
    output logic [7:0] level,
    output logic       active
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;
    state_t        state, state_nx;
    logic [7:0]    level_nx;
    logic [CW-1:0] cnt;
    logic          prev_gate;
    logic [3:0]    prev_note;
    logic          gate, rise, fall, retrig, tick, gated;
    logic [8:0]    att_sum, dec_diff, rel_diff;
    logic [7:0]    att_sat, dec_sat, rel_sat;
    logic [16:0]   product;
    assign gate    = |note;
    assign rise    = gate & ~prev_gate;
    assign fall    = ~gate & prev_gate;
    assign retrig  = gate & prev_gate & (note != prev_note);
    assign tick    = sample_now & (cnt == CW'(TICK_DIV - 1));
    assign gated   = (state == ATTACK) | (state == DECAY) | (state == SUSTAIN);
    assign active  = state != IDLE;
    // 9-bit intermediates: bit 8 flags overflow on the add and borrow on the subtracts
    assign att_sum  = {1'b0, level} + 9'(ATTACK_STEP);
    assign dec_diff = {1'b0, level} - 9'(DECAY_STEP);
    assign rel_diff = {1'b0, level} - 9'(RELEASE_STEP);
    assign att_sat  = att_sum[8] ? 8'hFF : att_sum[7:0];
    assign dec_sat  = (dec_diff[8] || dec_diff[7:0] < 8'(SUSTAIN_LEVEL)) ? 8'(SUSTAIN_LEVEL) : dec_diff[7:0];
    assign rel_sat  = rel_diff[8] ? 8'h00 : rel_diff[7:0];
    assign product  = 17'(sample_in) * 17'(level);
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            level <= '0;
        end else begin
            state <= state_nx;
            level <= level_nx;
        end
    end
    // gate events win over a coincident tick: state changes, level holds
    always_comb begin
        state_nx = state;
        level_nx = level;
        if (fall && gated) begin
            state_nx = RELEASE;
        end else if (rise || retrig) begin
            state_nx = ATTACK;
        end else if (tick && state == ATTACK) begin
            level_nx = att_sat;
            state_nx = att_sat == 8'hFF ? DECAY : ATTACK;
        end else if (tick && state == DECAY) begin
            level_nx = dec_sat;
            state_nx = dec_sat == 8'(SUSTAIN_LEVEL) ? SUSTAIN : DECAY;
        end else if (tick && state == RELEASE) begin
            level_nx = rel_sat;
            state_nx = rel_sat == 8'h00 ? IDLE : RELEASE;
        end
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt       <= '0;
            prev_gate <= 1'b0;
            prev_note <= '0;
        end else begin
            cnt       <= (rise | retrig) ? '0 : sample_now ? (tick ? '0 : cnt + CW'(1)) : cnt;
            prev_gate <= gate;
            prev_note <= note;
        end
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sample_out <= '0;
            done_out   <= 1'b0;
        end else begin
            done_out <= done_in;
            if (done_in) sample_out <= product[16:8];
        end
    end
endmodule
